// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS main controller.
// Contents: controller state enum, opcode values, ALU / PC / ALU-B select
// codes, the packed bundle of control outputs, and small decode helpers.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_RTYPE,
    S_ALUWB,
    S_BEQ,
    S_IMMEX,
    S_JUMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_LOGIC = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // Every control output of the FSM, bundled so that reset gating can
  // blank all of them in one assignment.
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       ext_zero;
    logic       illegal_op;
    logic       mem_err;
  } ctrl_out_t;

  // andi/ori treat their immediate as unsigned.
  function automatic logic is_zero_ext(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI);
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW};
  endfunction

  // States that hold a memory request open and wait on mem_ready.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mips_ctrl_if.sv
// Control bus between the main controller and the multi-cycle datapath.
// master: controller side (reads opcode/zero/mem_ready, drives controls).
// slave:  datapath side (drives opcode/zero/mem_ready, reads controls).
interface mips_ctrl_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_write;
  logic       i_or_d;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       ext_zero;
  logic       illegal_op;
  logic       mem_err;

  modport master (
    input  opcode, zero, mem_ready,
    output mem_req, mem_write, i_or_d, ir_write, pc_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, ext_zero,
           illegal_op, mem_err
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  mem_req, mem_write, i_or_d, ir_write, pc_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, ext_zero,
           illegal_op, mem_err
  );
endinterface

// File: rtl/mips_ctrl_out_decode.sv
// Purely combinational output decoder of the multi-cycle MIPS controller.
// Ports: state (current FSM state), opcode (live IR[31:26]), latched_op
// (opcode captured in S_DECODE), zero (ALU flag), mem_ready (memory
// handshake), wait_full (wait counter at its last allowed value),
// ctrl (all control outputs, before reset gating).
module mips_ctrl_out_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic [5:0] latched_op,
  input  logic       zero,
  input  logic       mem_ready,
  input  logic       wait_full,
  output ctrl_out_t  ctrl
);

  // One control word per state. A memory state that is still waiting when
  // the wait counter is full abandons the access: the request and write
  // strobe drop and mem_err pulses instead. The live opcode is only looked
  // at in S_DECODE and S_IMMEX; everywhere else the latched copy is used so
  // that the outputs do not follow IR changes between instructions.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_src    = PC_ALU;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
        end else if (wait_full) begin
          ctrl.mem_req = 1'b0;
          ctrl.mem_err = 1'b1;
        end
      end
      S_DECODE: begin
        ctrl.alu_src_b  = SRCB_IMM_SH;
        ctrl.alu_op     = ALU_ADD;
        ctrl.illegal_op = !is_legal(opcode);
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMRD, S_MEMWR: begin
        ctrl.mem_req   = 1'b1;
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_write = (state == S_MEMWR);
        if (!mem_ready && wait_full) begin
          ctrl.mem_req   = 1'b0;
          ctrl.mem_write = 1'b0;
          ctrl.mem_err   = 1'b1;
        end
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_RTYPE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
        ctrl.reg_dst   = 1'b1;
      end
      S_IMMEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = is_zero_ext(opcode) ? ALU_LOGIC : ALU_ADD;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = (latched_op == OP_RTYPE);
      end
      S_BEQ: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = PC_ALUOUT;
        ctrl.pc_write  = zero;
      end
      S_JUMP: begin
        ctrl.pc_src   = PC_JUMP;
        ctrl.pc_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
    if ((state == S_DECODE) || (state == S_IMMEX)) begin
      ctrl.ext_zero = is_zero_ext(opcode);
    end else begin
      ctrl.ext_zero = is_zero_ext(latched_op);
    end
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS datapath.
// Ports: clk (rising-edge clock), rst (synchronous active-high reset),
// bus (mips_ctrl_if master: opcode/zero/mem_ready in, control outputs out).
// Holds the state register, the memory wait counter and the opcode latched
// in S_DECODE; output decoding lives in mips_ctrl_out_decode.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  mips_ctrl_if.master bus
);

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [5:0]        op_q, op_d;
  ctrl_out_t         ctrl, ctrl_gated;

  // State register plus the two helper registers; reset returns the
  // controller to fetch with an empty wait count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      op_q    <= op_d;
    end
  end

  // Next-state logic. A memory timeout (reported by the decoder as
  // mem_err) sends loads/stores back to fetch, while fetch simply retries.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW:            state_d = S_MEMADR;
          OP_RTYPE:                state_d = S_RTYPE;
          OP_BEQ:                  state_d = S_BEQ;
          OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IMMEX;
          OP_J:                    state_d = S_JUMP;
          default:                 state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (bus.mem_ready)     state_d = S_MEMWB;
        else if (ctrl.mem_err) state_d = S_FETCH;
      end
      S_MEMWR:  if (bus.mem_ready || ctrl.mem_err) state_d = S_FETCH;
      S_RTYPE, S_IMMEX:                    state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BEQ, S_JUMP:     state_d = S_FETCH;
      default:                             state_d = S_FETCH;
    endcase
  end

  // The wait counter counts stalled cycles of the current memory access.
  // It restarts on any state change and after a timeout, so a retried
  // fetch gets a full new waiting window. The opcode is captured while in
  // S_DECODE so later states never depend on the live IR.
  always_comb begin
    op_d = (state_q == S_DECODE) ? bus.opcode : op_q;
    if ((state_d != state_q) || ctrl.mem_err) begin
      wait_d = '0;
    end else if (is_mem_state(state_q) && !bus.mem_ready) begin
      wait_d = wait_q + 1'b1;
    end else begin
      wait_d = wait_q;
    end
  end

  mips_ctrl_out_decode u_out_decode (
    .state      (state_q),
    .opcode     (bus.opcode),
    .latched_op (op_q),
    .zero       (bus.zero),
    .mem_ready  (bus.mem_ready),
    .wait_full  (wait_q == WAIT_LAST),
    .ctrl       (ctrl)
  );

  // While reset is held every enable, pulse and select is forced low, so
  // no write started before reset can complete in the reset cycle.
  always_comb begin
    ctrl_gated = rst ? '0 : ctrl;
  end

  assign bus.mem_req    = ctrl_gated.mem_req;
  assign bus.mem_write  = ctrl_gated.mem_write;
  assign bus.i_or_d     = ctrl_gated.i_or_d;
  assign bus.ir_write   = ctrl_gated.ir_write;
  assign bus.pc_write   = ctrl_gated.pc_write;
  assign bus.reg_write  = ctrl_gated.reg_write;
  assign bus.reg_dst    = ctrl_gated.reg_dst;
  assign bus.mem_to_reg = ctrl_gated.mem_to_reg;
  assign bus.alu_src_a  = ctrl_gated.alu_src_a;
  assign bus.alu_src_b  = ctrl_gated.alu_src_b;
  assign bus.alu_op     = ctrl_gated.alu_op;
  assign bus.pc_src     = ctrl_gated.pc_src;
  assign bus.ext_zero   = ctrl_gated.ext_zero;
  assign bus.illegal_op = ctrl_gated.illegal_op;
  assign bus.mem_err    = ctrl_gated.mem_err;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Testbench for mips_multicycle_ctrl: each instruction is expanded by a
// cycle-level reference model into a plan of expected control words, the
// plan is replayed against the DUT one clock at a time.
module tb_mips_multicycle_ctrl;

  localparam int TIMEOUT = 16;

  localparam logic [5:0] T_R    = 6'b000000;
  localparam logic [5:0] T_J    = 6'b000010;
  localparam logic [5:0] T_BEQ  = 6'b000100;
  localparam logic [5:0] T_ADDI = 6'b001000;
  localparam logic [5:0] T_ANDI = 6'b001100;
  localparam logic [5:0] T_ORI  = 6'b001101;
  localparam logic [5:0] T_LW   = 6'b100011;
  localparam logic [5:0] T_SW   = 6'b101011;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       ext_zero;
    logic       illegal_op;
    logic       mem_err;
  } outv_t;

  typedef struct {
    outv_t      o;
    logic       rdy;
    logic       z;
    logic       rs;
    logic [5:0] op;
  } step_t;

  logic clk;
  logic rst;
  mips_ctrl_if bus ();

  mips_multicycle_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  step_t      plan[$];
  logic [5:0] prev_op;
  int         checks;
  int         passes;
  int         fails;

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic zx(input logic [5:0] op);
    return (op == T_ANDI) || (op == T_ORI);
  endfunction

  function automatic logic legal(input logic [5:0] op);
    return op inside {T_R, T_J, T_BEQ, T_ADDI, T_ANDI, T_ORI, T_LW, T_SW};
  endfunction

  task automatic push_step(input outv_t o, input logic rdy, input logic [5:0] op,
                           input logic z, input logic rs);
    step_t s;
    s.o = o; s.rdy = rdy; s.op = op; s.z = z; s.rs = rs;
    plan.push_back(s);
  endtask

  // Stalled cycles of one memory access: the 16th consecutive stalled
  // cycle reports mem_err without request or write; fetch keeps waiting
  // afterwards, a data access is abandoned.
  task automatic plan_wait(input outv_t base, input int stalls, input logic is_fetch,
                           input logic [5:0] op, output logic aborted);
    outv_t e;
    int    k;
    k = 0;
    aborted = 1'b0;
    for (int i = 0; i < stalls; i++) begin
      if (k == TIMEOUT - 1) begin
        e = base;
        e.mem_req = 1'b0; e.mem_write = 1'b0; e.mem_err = 1'b1;
        push_step(e, 1'b0, op, rbit(), 1'b0);
        k = 0;
        if (!is_fetch) begin
          aborted = 1'b1;
          return;
        end
      end else begin
        push_step(base, 1'b0, op, rbit(), 1'b0);
        k++;
      end
    end
  endtask

  // Reference model of one complete instruction: fetch, decode, then the
  // class-specific steps, with fs/ms stalled cycles on the fetch and data
  // accesses and z as the ALU zero flag seen in the branch cycle.
  task automatic plan_instr(input logic [5:0] op, input int fs, input int ms, input logic z);
    outv_t v;
    logic  ab;
    v = '0; v.mem_req = 1'b1; v.alu_src_b = 2'b01; v.ext_zero = zx(prev_op);
    plan_wait(v, fs, 1'b1, prev_op, ab);
    v.ir_write = 1'b1; v.pc_write = 1'b1;
    push_step(v, 1'b1, prev_op, rbit(), 1'b0);
    v = '0; v.alu_src_b = 2'b11; v.ext_zero = zx(op); v.illegal_op = !legal(op);
    push_step(v, rbit(), op, rbit(), 1'b0);
    case (op)
      T_LW, T_SW: begin
        v = '0; v.alu_src_a = 1'b1; v.alu_src_b = 2'b10;
        push_step(v, rbit(), op, rbit(), 1'b0);
        v = '0; v.mem_req = 1'b1; v.i_or_d = 1'b1; v.mem_write = (op == T_SW);
        plan_wait(v, ms, 1'b0, op, ab);
        if (!ab) begin
          push_step(v, 1'b1, op, rbit(), 1'b0);
          if (op == T_LW) begin
            v = '0; v.reg_write = 1'b1; v.mem_to_reg = 1'b1;
            push_step(v, rbit(), op, rbit(), 1'b0);
          end
        end
      end
      T_R: begin
        v = '0; v.alu_src_a = 1'b1; v.alu_op = 2'b10; v.reg_dst = 1'b1;
        push_step(v, rbit(), op, rbit(), 1'b0);
        v = '0; v.reg_write = 1'b1; v.reg_dst = 1'b1;
        push_step(v, rbit(), op, rbit(), 1'b0);
      end
      T_ADDI, T_ANDI, T_ORI: begin
        v = '0; v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; v.ext_zero = zx(op);
        v.alu_op = (op == T_ADDI) ? 2'b00 : 2'b11;
        push_step(v, rbit(), op, rbit(), 1'b0);
        v = '0; v.reg_write = 1'b1; v.ext_zero = zx(op);
        push_step(v, rbit(), op, rbit(), 1'b0);
      end
      T_BEQ: begin
        v = '0; v.alu_src_a = 1'b1; v.alu_op = 2'b01; v.pc_src = 2'b01; v.pc_write = z;
        push_step(v, rbit(), op, z, 1'b0);
      end
      T_J: begin
        v = '0; v.pc_src = 2'b10; v.pc_write = 1'b1;
        push_step(v, rbit(), op, rbit(), 1'b0);
      end
      default: ;
    endcase
    prev_op = op;
  endtask

  task automatic plan_reset_cycle();
    push_step('0, rbit(), 6'b000000, rbit(), 1'b1);
    prev_op = 6'b000000;
  endtask

  // Drive one cycle's inputs after the falling edge and sample the
  // combinational outputs shortly afterwards.
  task automatic drive_step(input step_t s, output outv_t obs);
    @(negedge clk);
    rst           = s.rs;
    bus.opcode    = s.op;
    bus.mem_ready = s.rdy;
    bus.zero      = s.z;
    #1;
    obs = {bus.mem_req, bus.mem_write, bus.i_or_d, bus.ir_write, bus.pc_write,
           bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b,
           bus.alu_op, bus.pc_src, bus.ext_zero, bus.illegal_op, bus.mem_err};
  endtask

  task automatic test_reset();
    step_t s;
    outv_t obs;
    int    n;
    plan_reset_cycle();
    plan_reset_cycle();
    plan_instr(T_J, 0, 0, 1'b0);
    n = 0;
    while (plan.size() > 0) begin
      s = plan.pop_front();
      drive_step(s, obs);
      checks++;
      if (obs !== s.o) begin
        fails++;
        $display("[TB] FAIL reset cycle %0d: got %05h expected %05h", n, obs, s.o);
      end else passes++;
      n++;
    end
  endtask

  task automatic test_lw();
    step_t s;
    outv_t obs;
    int    n, rw_cnt, rw_at;
    plan_instr(T_LW, 0, 0, rbit());
    n = 0; rw_cnt = 0; rw_at = 0;
    while (plan.size() > 0) begin
      s = plan.pop_front();
      drive_step(s, obs);
      if (obs.reg_write) begin
        rw_cnt++;
        rw_at = n + 1;
      end
      checks++;
      if (obs !== s.o) begin
        fails++;
        $display("[TB] FAIL lw cycle %0d: got %05h expected %05h", n, obs, s.o);
      end else passes++;
      n++;
    end
    checks++;
    if (rw_cnt !== 1 || rw_at !== 5) begin
      fails++;
      $display("[TB] FAIL lw_writeback: got %0d writes at cycle %0d, expected 1 at cycle 5", rw_cnt, rw_at);
    end else passes++;
  endtask

  task automatic test_fetch_stall();
    step_t s;
    outv_t obs;
    int    n, ir_cnt, ir_at;
    plan_instr(T_ADDI, 3, 0, rbit());
    n = 0; ir_cnt = 0; ir_at = 0;
    while (plan.size() > 0) begin
      s = plan.pop_front();
      drive_step(s, obs);
      if (obs.ir_write && obs.pc_write) begin
        ir_cnt++;
        ir_at = n + 1;
      end
      checks++;
      if (obs !== s.o) begin
        fails++;
        $display("[TB] FAIL fetch_stall cycle %0d: got %05h expected %05h", n, obs, s.o);
      end else passes++;
      n++;
    end
    checks++;
    if (ir_cnt !== 1 || ir_at !== 4) begin
      fails++;
      $display("[TB] FAIL fetch_pulse: got %0d pulses at cycle %0d, expected 1 at cycle 4", ir_cnt, ir_at);
    end else passes++;
  endtask

  task automatic test_branch_imm_illegal();
    step_t s;
    outv_t obs;
    int    n;
    plan_instr(T_BEQ, 0, 0, 1'b0);
    plan_instr(T_BEQ, 1, 0, 1'b1);
    plan_instr(T_ORI, 0, 0, rbit());
    plan_instr(T_ADDI, 0, 0, rbit());
    plan_instr(T_ANDI, 2, 0, rbit());
    plan_instr(6'b111111, 0, 0, rbit());
    plan_instr(T_J, 0, 0, rbit());
    plan_instr(T_R, 0, 0, rbit());
    n = 0;
    while (plan.size() > 0) begin
      s = plan.pop_front();
      drive_step(s, obs);
      checks++;
      if (obs !== s.o) begin
        fails++;
        $display("[TB] FAIL branch_imm_illegal cycle %0d: got %05h expected %05h", n, obs, s.o);
      end else passes++;
      n++;
    end
  endtask

  task automatic test_timeout();
    step_t s;
    outv_t obs;
    int    n;
    plan_instr(T_SW, 0, 16, rbit());
    plan_instr(T_LW, 0, 20, rbit());
    plan_instr(T_R, 20, 0, rbit());
    plan_instr(T_SW, 0, 15, rbit());
    n = 0;
    while (plan.size() > 0) begin
      s = plan.pop_front();
      drive_step(s, obs);
      checks++;
      if (obs !== s.o) begin
        fails++;
        $display("[TB] FAIL timeout cycle %0d: got %05h expected %05h", n, obs, s.o);
      end else passes++;
      n++;
    end
  endtask

  task automatic test_reset_mid();
    step_t s;
    outv_t obs;
    int    n;
    plan_instr(T_LW, 0, 1, rbit());
    void'(plan.pop_back());
    plan_reset_cycle();
    plan_instr(T_ORI, 0, 0, rbit());
    void'(plan.pop_back());
    plan_reset_cycle();
    plan_instr(T_R, 0, 0, rbit());
    n = 0;
    while (plan.size() > 0) begin
      s = plan.pop_front();
      drive_step(s, obs);
      checks++;
      if (obs !== s.o) begin
        fails++;
        $display("[TB] FAIL reset_mid cycle %0d: got %05h expected %05h", n, obs, s.o);
      end else passes++;
      n++;
    end
  endtask

  task automatic test_random();
    step_t      s;
    outv_t      obs;
    int         n;
    logic [5:0] ops[10];
    ops = '{T_R, T_J, T_BEQ, T_ADDI, T_ANDI, T_ORI, T_LW, T_SW, 6'b111111, 6'b010101};
    for (int i = 0; i < 60; i++) begin
      plan_instr(ops[$urandom_range(0, 9)], $urandom_range(0, 3), $urandom_range(0, 3), rbit());
    end
    n = 0;
    while (plan.size() > 0) begin
      s = plan.pop_front();
      drive_step(s, obs);
      checks++;
      if (obs !== s.o) begin
        fails++;
        $display("[TB] FAIL random cycle %0d: got %05h expected %05h", n, obs, s.o);
      end else passes++;
      n++;
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.opcode    = 6'b000000;
    bus.mem_ready = 1'b0;
    bus.zero      = 1'b0;
    prev_op       = 6'b000000;
    checks        = 0;
    passes        = 0;
    fails         = 0;
    test_reset();
    test_lw();
    test_fetch_stall();
    test_branch_imm_illegal();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
